// File: rtl/nor_vector_checker_if.sv
// ============================================================================
// nor_vector_checker_if : stimulus/response bundle between the checker and the
//                         NOR compare gate it exercises.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nor_vector_checker_if #(
   parameter int N_IN  = 3,
   parameter int ERR_W = 4
) ();

   logic             start;
   logic [N_IN-1:0]  vec_out;
   logic             dut_out_3in;
   logic             dut_out_inst;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [N_IN-1:0]  first_err_vec;
   logic             first_err_valid;

   // Controller / gate side of the bundle
   modport master (
      output start, dut_out_3in, dut_out_inst,
      input  vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );

   // Checker side of the bundle
   modport slave (
      input  start, dut_out_3in, dut_out_inst,
      output vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );

endinterface

`default_nettype wire

// File: rtl/nor_vector_checker.sv
// ============================================================================
// nor_vector_checker : walks every input vector through the NOR compare gate
//                      and checks both gate outputs against the golden NOR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nor_vector_checker #(
   parameter int N_IN       = 3,
   parameter int SETTLE_CYC = 1,
   parameter int ERR_W      = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   nor_vector_checker_if.slave   bus
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0]  VEC_LAST   = '1;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  settle_cnt;
   logic [N_IN-1:0]   vec;
   logic [ERR_W-1:0]  err;
   logic [N_IN-1:0]   fe_vec;
   logic              fe_valid;
   logic              busy;
   logic              done;
   logic              pass;

   logic              exp_nor;
   logic              mismatch;
   logic [ERR_W-1:0]  err_next;

   // A vector contributes at most one error even if both gate forms disagree
   always_comb begin
      exp_nor  = ~|vec;
      mismatch = (bus.dut_out_3in != exp_nor) || (bus.dut_out_inst != exp_nor);
      err_next = err;
      if (mismatch && (err != ERR_MAX)) begin
         err_next = err + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         vec        <= '0;
         err        <= '0;
         fe_vec     <= '0;
         fe_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= SETTLE;
                  vec        <= '0;
                  settle_cnt <= CNT_RELOAD;
                  err        <= '0;
                  fe_vec     <= '0;
                  fe_valid   <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end

            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end

            CHECK: begin
               err <= err_next;
               if (mismatch && !fe_valid) begin
                  fe_vec   <= vec;
                  fe_valid <= 1'b1;
               end
               // Stop after the all-ones vector rather than wrapping
               if (vec == VEC_LAST) begin
                  state <= DONE;
                  vec   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  vec        <= vec + 1'b1;
                  settle_cnt <= CNT_RELOAD;
                  state      <= SETTLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.vec_out         = vec;
   assign bus.busy            = busy;
   assign bus.done            = done;
   assign bus.pass            = pass;
   assign bus.err_cnt         = err;
   assign bus.first_err_vec   = fe_vec;
   assign bus.first_err_valid = fe_valid;

endmodule

`default_nettype wire
